// File: rtl/cnn_pkg.sv
// Shared constants and types for the convolution window generator.
package cnn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int KERNEL     = 5;
  localparam int MAX_IMG    = 32;
  localparam int SIZE_W     = 6;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  // Element (r,c) sits at index r*KERNEL+c, so the flat vector matches the conv datapath layout.
  typedef pixel_t [KERNEL*KERNEL-1:0] window_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } wg_state_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Control, pixel-in and window-out signals of the window generator.
// stride2 only exists when CONV_WINDOW_STRIDE_EN is defined.
interface conv_window_gen_if #(
  parameter int SIZE_W = cnn_pkg::SIZE_W
);
  import cnn_pkg::*;

  logic              start;
  logic [SIZE_W-1:0] img_size;
`ifdef CONV_WINDOW_STRIDE_EN
  logic              stride2;
`endif
  logic              in_valid;
  pixel_t            in_data;
  logic              in_ready;
  logic              win_valid;
  window_t           win_data;
  logic              win_ready;
  logic              busy;
  logic              done;

  modport master (
`ifdef CONV_WINDOW_STRIDE_EN
    output stride2,
`endif
    output start, img_size, in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data, busy, done
  );

  modport slave (
`ifdef CONV_WINDOW_STRIDE_EN
    input  stride2,
`endif
    input  start, img_size, in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data, busy, done
  );

endinterface

// File: rtl/conv_line_buffer.sv
// One image row of delay: a circular buffer whose wrap point is the run-time row length.
// The output is the pixel written exactly len_i advances earlier.
module conv_line_buffer
  import cnn_pkg::*;
#(
  parameter int MAX_IMG = cnn_pkg::MAX_IMG,
  parameter int SIZE_W  = cnn_pkg::SIZE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              adv_i,
  input  logic [SIZE_W-1:0] len_i,
  input  pixel_t            din_i,
  output pixel_t            dout_o
);

  localparam int AW = (MAX_IMG > 1) ? $clog2(MAX_IMG) : 1;

  pixel_t            mem [MAX_IMG];
  logic [SIZE_W-1:0] ptr_q, ptr_d;

  assign dout_o = mem[ptr_q[AW-1:0]];

  // Pointer steps once per accepted pixel and wraps at the current row length.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (adv_i) begin
      ptr_d = (ptr_q == len_i - SIZE_W'(1)) ? '0 : ptr_q + SIZE_W'(1);
    end
  end

  // Pointer register; contents of the row memory are never reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Old pixel is read out and the new one overwrites it in the same slot.
  always_ff @(posedge clk) begin
    if (adv_i) begin
      mem[ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KERNEL x KERNEL sliding-window generator (stride 1, no padding).
// Optional CONV_WINDOW_STRIDE_EN adds a stride2 control that keeps only even-origin windows.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int MAX_IMG = cnn_pkg::MAX_IMG,
  parameter int SIZE_W  = cnn_pkg::SIZE_W
) (
  input logic              clk,
  input logic              rst_n,
  conv_window_gen_if.slave wg
);

  localparam logic [SIZE_W-1:0] KSZ  = SIZE_W'(KERNEL);
  localparam logic [SIZE_W-1:0] KM1  = SIZE_W'(KERNEL - 1);
  localparam logic [SIZE_W-1:0] MAXN = SIZE_W'(MAX_IMG);

  wg_state_t         state_q, state_d;
  logic [SIZE_W-1:0] n_q, n_d, row_q, row_d, col_q, col_d;
  logic              stride_q, stride_d, stride_start;
  logic              win_valid_q, win_valid_d;
  window_t           win_q, win_d;

  logic              in_ready, accept, frame_start, size_ok;
  logic              last_col, last_pix, emit;
  pixel_t            col_px [KERNEL];
  pixel_t            lb_out [KERNEL-1];

`ifdef CONV_WINDOW_STRIDE_EN
  assign stride_start = wg.stride2;
`else
  assign stride_start = 1'b0;
`endif

  assign frame_start = (state_q == IDLE) && wg.start;
  assign size_ok     = (wg.img_size >= KSZ) && (wg.img_size <= MAXN);
  assign in_ready    = (state_q == FILL) && (!win_valid_q || wg.win_ready);
  assign accept      = wg.in_valid && in_ready;
  assign last_col    = (col_q == n_q - SIZE_W'(1));
  assign last_pix    = last_col && (row_q == n_q - SIZE_W'(1));

  // The origin is (row-KERNEL+1, col-KERNEL+1), so its parity follows from bit 0 of row/col.
  assign emit = (row_q >= KM1) && (col_q >= KM1) &&
                (!stride_q || ((row_q[0] == KM1[0]) && (col_q[0] == KM1[0])));

  // Chain of row delays: stage k delivers the pixel k+1 rows above the incoming one.
  for (genvar k = 0; k < KERNEL - 1; k++) begin : g_lb
    pixel_t lb_in;
    if (k == 0) begin : g_head
      assign lb_in = wg.in_data;
    end else begin : g_tail
      assign lb_in = lb_out[k-1];
    end
    conv_line_buffer #(
      .MAX_IMG (MAX_IMG),
      .SIZE_W  (SIZE_W)
    ) u_lb (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (frame_start),
      .adv_i   (accept),
      .len_i   (n_q),
      .din_i   (lb_in),
      .dout_o  (lb_out[k])
    );
  end

  // Assemble the incoming column (oldest row on top) and shift it into the window.
  always_comb begin
    col_px[KERNEL-1] = wg.in_data;
    for (int k = 0; k < KERNEL - 1; k++) begin
      col_px[KERNEL-2-k] = lb_out[k];
    end
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) begin
          win_d[r*KERNEL+c] = win_q[r*KERNEL+c+1];
        end
        win_d[r*KERNEL+KERNEL-1] = col_px[r];
      end
    end
  end

  // Counters, latched frame settings and the window-valid flag.
  always_comb begin
    n_d         = n_q;
    stride_d    = stride_q;
    row_d       = row_q;
    col_d       = col_q;
    win_valid_d = win_valid_q;
    if (frame_start) begin
      n_d      = wg.img_size;
      stride_d = stride_start;
      row_d    = '0;
      col_d    = '0;
    end else if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + SIZE_W'(1);
      end else begin
        col_d = col_q + SIZE_W'(1);
      end
    end
    if (accept) begin
      win_valid_d = emit;
    end else if (wg.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wg.start) state_d = size_ok ? FILL : DONE;
      FILL:    if (accept && last_pix) state_d = DRAIN;
      DRAIN:   if (!win_valid_q || wg.win_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      stride_q    <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      stride_q    <= stride_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      win_q       <= win_d;
    end
  end

  // Outputs decoded from state and registers.
  always_comb begin
    wg.in_ready  = in_ready;
    wg.win_valid = win_valid_q;
    wg.win_data  = win_q;
    wg.busy      = (state_q != IDLE);
    wg.done      = (state_q == DONE);
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: full frames, stalls, bad sizes, restart and reset.
// Windows are predicted from the pixel formula base + row*N + col.
module tb_conv_window_gen;

  localparam int DW = 16;
  localparam int K  = 5;
  localparam int WB = K * K * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  conv_window_gen_if ifc ();

  conv_window_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wg    (ifc)
  );

  int checks   = 0;
  int failures = 0;

  int winIdx, doneCnt, doneCyc, lastHs;
  bit sawInReady;
  bit aborted;

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected k-th window of a frame whose pixel (r,c) equals base + r*n + c.
  function automatic logic [WB-1:0] expWindow(input int n, input int base, input int k, input bit s2);
    int step, w, orow, ocol;
    logic [WB-1:0] v;
    step = s2 ? 2 : 1;
    w    = (n - K) / step + 1;
    orow = (k / w) * step;
    ocol = (k % w) * step;
    v    = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        v[(r*K+c)*DW +: DW] = DW'(base + (orow + r) * n + ocol + c);
      end
    end
    return v;
  endfunction

  // Run one frame; inputs change #1 after posedge, everything is sampled on negedge.
  task automatic applyStimulus(input int n, input int base, input bit randReady, input bit s2,
                               input int glitchCyc, input int abortAt);
    int cyc, pixIdx, expWins, step, w;
    bit validN, stallPrev;
    logic [WB-1:0] prevData;
    validN     = (n >= K) && (n <= 32);
    step       = s2 ? 2 : 1;
    w          = (n - K) / step + 1;
    expWins    = validN ? w * w : 0;
    cyc        = 0;
    pixIdx     = 0;
    winIdx     = 0;
    doneCnt    = 0;
    doneCyc    = -100;
    lastHs     = -100;
    sawInReady = 1'b0;
    stallPrev  = 1'b0;
    prevData   = '0;
    aborted    = 1'b0;
    while (cyc < 8000) begin
      ifc.start     = (cyc == 0) || (cyc == glitchCyc);
      ifc.img_size  = (cyc == 0) ? 6'(n) : 6'd4;
`ifdef CONV_WINDOW_STRIDE_EN
      ifc.stride2   = s2;
`endif
      ifc.in_valid  = (pixIdx < n * n);
      ifc.in_data   = DW'(base + pixIdx);
      ifc.win_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (cyc == 1) checkOutput("busy_running", ifc.busy, 1'b1);
      if (stallPrev) checkOutput("stall_hold", {ifc.win_valid, ifc.win_data}, {1'b1, prevData});
      if (ifc.win_valid && !ifc.win_ready) checkOutput("stall_no_accept", ifc.in_ready, 1'b0);
      if (ifc.in_ready) sawInReady = 1'b1;
      if (ifc.in_valid && ifc.in_ready) pixIdx++;
      if (ifc.win_valid && ifc.win_ready) begin
        if (winIdx < expWins) begin
          checkOutput($sformatf("win_%0d_n%0d", winIdx, n), ifc.win_data, expWindow(n, base, winIdx, s2));
        end else begin
          checkOutput("extra_window", winIdx, expWins);
        end
        lastHs = cyc;
        winIdx++;
      end
      if (ifc.done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      stallPrev = ifc.win_valid && !ifc.win_ready;
      prevData  = ifc.win_data;
      if (abortAt > 0 && pixIdx == abortAt) begin
        aborted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (doneCnt > 0 && cyc >= doneCyc + 4) break;
    end
    ifc.start    = 1'b0;
    ifc.in_valid = 1'b0;
    if (!aborted) begin
      checkOutput($sformatf("win_count_n%0d", n), winIdx, expWins);
      checkOutput($sformatf("done_count_n%0d", n), doneCnt, 1);
      checkOutput($sformatf("busy_idle_n%0d", n), ifc.busy, 1'b0);
      if (validN) begin
        checkOutput($sformatf("done_timing_n%0d", n), doneCyc, lastHs + 1);
      end else begin
        checkOutput($sformatf("done_timing_n%0d", n), doneCyc, 1);
        checkOutput($sformatf("no_in_ready_n%0d", n), sawInReady, 1'b0);
      end
    end
  endtask

  // Asynchronous reset values, checked away from any clock edge.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, ifc.in_ready, 1'b0);
    checkOutput({tag, "_win_valid"}, ifc.win_valid, 1'b0);
    checkOutput({tag, "_win_data"}, ifc.win_data, '0);
    checkOutput({tag, "_busy"}, ifc.busy, 1'b0);
    checkOutput({tag, "_done"}, ifc.done, 1'b0);
  endtask

  initial begin
    ifc.start     = 1'b0;
    ifc.img_size  = '0;
`ifdef CONV_WINDOW_STRIDE_EN
    ifc.stride2   = 1'b0;
`endif
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.win_ready = 1'b0;
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] N=32, always ready");
    applyStimulus(32, 0, 1'b0, 1'b0, -1, -1);
    $display("[TB] N=32, random win_ready");
    applyStimulus(32, 0, 1'b1, 1'b0, -1, -1);
    $display("[TB] N=4 and N=40, out of range");
    applyStimulus(4, 0, 1'b0, 1'b0, -1, -1);
    applyStimulus(40, 0, 1'b0, 1'b0, -1, -1);
    $display("[TB] N=5, single window, high data bits");
    applyStimulus(5, 40000, 1'b1, 1'b0, -1, -1);
    $display("[TB] N=32 with start pulsed mid-frame");
    applyStimulus(32, 500, 1'b0, 1'b0, 300, -1);

    $display("[TB] reset after 100 pixels");
    applyStimulus(32, 0, 1'b0, 1'b0, -1, 100);
    checkOutput("abort_reached", aborted, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("no_done_after_reset", ifc.done, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(8, 1000, 1'b1, 1'b0, -1, -1);

`ifdef CONV_WINDOW_STRIDE_EN
    $display("[TB] N=32 stride2");
    applyStimulus(32, 0, 1'b1, 1'b1, -1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
